// File: rtl/and_filter_n_if.sv
// Lane inputs, reduction controls and filtered outputs of the AND/OR debounce filter.
// The master drives lanes and controls; the slave (the filter) drives the results.
interface and_filter_n_if #(
    parameter int N = 2
);
    logic [N-1:0] din;
    logic [N-1:0] mask;
    logic         op;
    logic         dout;
    logic         dout_rise;
    logic         dout_fall;
    logic         valid;

    modport master (
        output din, mask, op,
        input  dout, dout_rise, dout_fall, valid
    );

    modport slave (
        input  din, mask, op,
        output dout, dout_rise, dout_fall, valid
    );
endinterface

// File: rtl/and_filter_n.sv
// Synchronises and debounces N asynchronous lanes, then reduces the masked lanes with AND or OR
// into a registered output with edge pulses that are held off until the startup settle time passes.
module and_filter_n #(
    parameter int N           = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    and_filter_n_if.slave bus
);

    localparam int              CW       = $clog2(FILT_LEN + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(FILT_LEN - 1);
    localparam int              START    = SYNC_STAGES + FILT_LEN + 1;
    localparam int              SW       = $clog2(START);
    localparam logic [SW-1:0]   ST_LAST  = SW'(START - 1);

    logic [SYNC_STAGES-1:0] sync_q [N];
    logic [CW-1:0]          cnt_q  [N];
    logic [N-1:0]           stable_q;
    logic [SW-1:0]          st_cnt_q;
    logic                   valid_q;
    logic                   dout_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   reduced;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                sync_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            stable_q <= '0;
        end else begin
            for (int i = 0; i < N; i++) begin
                sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.din[i]};
                // A lane flips only after FILT_LEN consecutive cycles disagreeing with its stable value.
                if (sync_q[i][SYNC_STAGES-1] == stable_q[i]) begin
                    cnt_q[i] <= '0;
                end else if (cnt_q[i] == CNT_LAST) begin
                    stable_q[i] <= sync_q[i][SYNC_STAGES-1];
                    cnt_q[i]    <= '0;
                end else begin
                    cnt_q[i] <= cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Masked-off lanes become the identity element of the selected reduction.
    always_comb begin
        reduced = bus.op ? |(stable_q & bus.mask) : &(stable_q | ~bus.mask);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_cnt_q <= '0;
            valid_q  <= 1'b0;
        end else if (!valid_q) begin
            if (st_cnt_q == ST_LAST) begin
                valid_q <= 1'b1;
            end else begin
                st_cnt_q <= st_cnt_q + SW'(1);
            end
        end
    end

    // Pulses are gated by the pre-edge valid, so the edge that raises valid never pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout_q <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            dout_q <= reduced;
            rise_q <= valid_q &  reduced & ~dout_q;
            fall_q <= valid_q & ~reduced &  dout_q;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.dout_rise = rise_q;
    assign bus.dout_fall = fall_q;
    assign bus.valid     = valid_q;

endmodule

// File: doc/and_filter_n.md
AND_FILTER_N -- requirements
Module: and_filter_n

Interface
REQ-001 SHALL have parameter N, default 2: number of input lanes; N >= 1.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth per lane; SYNC_STAGES >= 2.
REQ-003 SHALL have parameter FILT_LEN, default 8: debounce length in cycles; FILT_LEN >= 1.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-006 SHALL have port din, input, N bits: asynchronous lane inputs (e.g. PS2 clock/data, enables).
REQ-007 SHALL have port mask, input, N bits: synchronous; 1 means the lane participates in the reduction.
REQ-008 SHALL have port op, input, 1 bit: synchronous; 0 = AND reduction, 1 = OR reduction.
REQ-009 SHALL have port dout, output, 1 bit: registered reduction of filtered lanes.
REQ-010 SHALL have port dout_rise, output, 1 bit: one-cycle pulse on dout 0->1.
REQ-011 SHALL have port dout_fall, output, 1 bit: one-cycle pulse on dout 1->0.
REQ-012 SHALL have port valid, output, 1 bit: high once the startup settle time has elapsed.

Function
REQ-013 SHALL pass each din lane through a SYNC_STAGES-deep flip-flop chain; the last stage is the lane's synced value.
REQ-014 SHALL keep per lane a stable bit and a counter of width clog2(FILT_LEN+1).
REQ-015 SHALL clear the lane counter in any cycle where the synced value equals stable.
REQ-016 SHALL increment the lane counter in any cycle where the synced value differs from stable and the counter is below FILT_LEN-1.
REQ-017 SHALL load stable with the synced value and clear the counter when they differ and the counter equals FILT_LEN-1: FILT_LEN consecutive differing cycles are required.
REQ-018 SHALL, for FILT_LEN = 1, update stable on the first differing cycle.
REQ-019 SHALL ignore any synced pulse shorter than FILT_LEN cycles; stable is unchanged and the counter returns to 0.
REQ-020 SHALL treat a masked-off lane (mask=0) as 1 for AND and 0 for OR.
REQ-021 SHALL, with mask all zeros, produce a reduction of 1 for op=0 and 0 for op=1.
REQ-022 SHALL register dout from the reduction of stable, mask and op every cycle.
REQ-023 SHALL give latency from a held din change to dout = SYNC_STAGES+FILT_LEN+1 rising edges (11 at defaults).
REQ-024 SHALL give latency from an op/mask change to dout = 1 rising edge; op and mask are not synchronised or filtered.
REQ-025 SHALL assert dout_rise / dout_fall for exactly one cycle, registered on the same edge dout changes, and only when valid is 1.
REQ-026 SHALL never assert dout_rise and dout_fall in the same cycle.
REQ-027 SHALL run a startup counter after reset release and set valid after SYNC_STAGES+FILT_LEN+1 edges (11 at defaults); valid then holds 1 until reset.
REQ-028 SHALL keep updating dout while valid is 0; only the edge pulses are suppressed.

Reset
REQ-029 SHALL, on reset_n low, asynchronously clear all synchroniser stages, stable bits, lane counters, the startup counter, dout, dout_rise, dout_fall and valid to 0.
REQ-030 SHALL, on reset asserted mid-debounce or mid-pulse, abort immediately; no pulse completes after reset.
REQ-031 SHALL release reset synchronously to clk; behaviour restarts exactly as from power-up.

Verification (N=2, SYNC_STAGES=2, FILT_LEN=8)
REQ-032 SHALL cover: reset release with din=00, op=0, mask=11 -> dout=0, valid=0 for 10 edges, valid=1 at edge 11, no pulses.
REQ-033 SHALL cover: after valid, din 00->11 held -> dout=1 exactly 11 edges later, dout_rise=1 for one cycle, dout_fall=0.
REQ-034 SHALL cover: din[0] 1->0 glitch of 5 cycles while din=11 -> dout stays 1, no pulse; the same glitch held 8+ synced cycles -> dout=0, dout_fall one cycle.
REQ-035 SHALL cover: din=01 stable, op=0, mask=11 -> dout=0; mask->01 -> dout=1 next edge with dout_rise; op->1, mask->00 -> dout=0 next edge with dout_fall.
REQ-036 SHALL cover: reset_n pulsed low at the 6th debounce cycle of din 00->11 -> all outputs 0 immediately; after release with din=11 held, dout=1 at edge 11 coincident with valid=1, dout_rise=0.
REQ-037 SHALL cover: FILT_LEN=1 build, din=11, 1-cycle din[1] low at the synced output -> dout drops for exactly one cycle 1 edge later, with dout_fall then dout_rise.
